// File: rtl/top_entity_pkg.sv
// Shared definitions for the event-queue stream evaluator: sizing constants
// and the queue-entry record passed from the input stage to evaluation.
package top_entity_pkg;

  localparam int DATA_W      = 64;
  localparam int PERIOD_B    = 10;
  localparam int WIN_BUCKETS = 2;
  localparam int QUEUE_DEPTH = 4;

  typedef struct packed {
    logic signed [DATA_W-1:0] x;
    logic                     new_x;
    logic                     tick_b;
  } q_entry_t;

endpackage

// File: rtl/top_entity_if.sv
// Push/pop handshake between the producer (master) and the event queue (slave).
interface top_entity_if;
  import top_entity_pkg::*;

  logic     push;
  q_entry_t push_data;
  logic     push_valid;
  logic     pop;
  q_entry_t head;
  logic     empty;
  logic     full;

  modport master (
    output push, push_data, pop,
    input  push_valid, head, empty, full
  );

  modport slave (
    input  push, push_data, pop,
    output push_valid, head, empty, full
  );

endinterface

// File: rtl/event_queue.sv
// Circular-buffer FIFO of queue entries; a push while full is accepted only
// when a pop frees a slot in the same cycle.
module event_queue
  import top_entity_pkg::*;
#(
  parameter int DEPTH = QUEUE_DEPTH
) (
  input logic         clk,
  input logic         rst,
  top_entity_if.slave q
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  q_entry_t         r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign q.empty      = (r_count == '0);
  assign q.full       = (r_count == CNT_W'(DEPTH));
  assign w_do_pop     = q.pop & ~q.empty;
  assign w_do_push    = q.push & (~q.full | w_do_pop);
  assign q.push_valid = w_do_push;
  assign q.head       = q.empty ? '0 : r_mem[r_rd_ptr];

  // NOTE: flop state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage is not reset; the empty flag masks stale contents from the head.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= q.push_data;
  end

endmodule

// File: rtl/top_entity.sv
// Stream evaluator: A follows every new x; B fires each PERIOD_B cycles with
// the sum of x over a sliding window of WIN_BUCKETS per-period buckets.
module top_entity #(
  parameter int DATA_W      = top_entity_pkg::DATA_W,
  parameter int PERIOD_B    = top_entity_pkg::PERIOD_B,
  parameter int WIN_BUCKETS = top_entity_pkg::WIN_BUCKETS,
  parameter int QUEUE_DEPTH = top_entity_pkg::QUEUE_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] input_x,
  input  logic                     new_input,
  output logic                     qPush,
  output logic                     qPop,
  output logic signed [DATA_W-1:0] qInX,
  output logic                     qPushValid,
  output logic                     qPopValid,
  output logic signed [DATA_W-1:0] qOutX,
  output logic                     qOutNewX,
  output logic signed [DATA_W-1:0] qWaitX,
  output logic                     enA,
  output logic                     enB,
  output logic signed [DATA_W-1:0] stage,
  output logic signed [DATA_W-1:0] timerB,
  output logic signed [DATA_W-1:0] winX_0,
  output logic signed [DATA_W-1:0] winX_1,
  output logic signed [DATA_W-1:0] outA,
  output logic                     aktvOutA,
  output logic signed [DATA_W-1:0] outB,
  output logic                     aktvOutB
);

  import top_entity_pkg::q_entry_t;

  localparam int TMR_W = (PERIOD_B > 1) ? $clog2(PERIOD_B) : 1;

  logic [TMR_W-1:0]         r_timer;
  logic                     w_tick;
  q_entry_t                 r_eval;
  logic                     r_eval_valid;
  logic signed [DATA_W-1:0] r_win [WIN_BUCKETS];
  logic signed [DATA_W-1:0] r_out_a;
  logic signed [DATA_W-1:0] r_out_b;
  logic                     r_aktv_a;
  logic                     r_aktv_b;
  logic signed [DATA_W-1:0] w_bucket;
  logic signed [DATA_W-1:0] w_win_sum;

  top_entity_if u_qif ();

  event_queue #(.DEPTH(QUEUE_DEPTH)) u_event_queue (
    .clk (clk),
    .rst (rst),
    .q   (u_qif.slave)
  );

  assign w_tick          = (r_timer == TMR_W'(PERIOD_B - 1));
  assign u_qif.push      = en & (new_input | w_tick);
  assign u_qif.push_data = '{x: input_x, new_x: new_input, tick_b: w_tick};
  assign u_qif.pop       = en & ~u_qif.empty;

  // Current bucket including the entry under evaluation.
  assign w_bucket = r_win[0] + (r_eval.new_x ? r_eval.x : '0);

  // NOTE: the sum is given its default first so no latch is inferred.
  always_comb begin
    w_win_sum = w_bucket;
    for (int i = 1; i < WIN_BUCKETS; i++) w_win_sum = w_win_sum + r_win[i];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_timer      <= '0;
      r_eval       <= '0;
      r_eval_valid <= 1'b0;
      r_win        <= '{default: '0};
      r_out_a      <= '0;
      r_out_b      <= '0;
      r_aktv_a     <= 1'b0;
      r_aktv_b     <= 1'b0;
    end else begin
      r_aktv_a <= 1'b0;
      r_aktv_b <= 1'b0;
      if (en) begin
        r_timer      <= w_tick ? '0 : r_timer + TMR_W'(1);
        r_eval_valid <= u_qif.pop;
        if (u_qif.pop) r_eval <= u_qif.head;
        if (r_eval_valid) begin
          if (r_eval.new_x) begin
            r_out_a  <= r_eval.x;
            r_aktv_a <= 1'b1;
          end
          // A tick closes the current bucket and slides the window by one period.
          if (r_eval.tick_b) begin
            r_out_b  <= w_win_sum;
            r_aktv_b <= 1'b1;
            r_win[0] <= '0;
            r_win[1] <= w_bucket;
            for (int i = 2; i < WIN_BUCKETS; i++) r_win[i] <= r_win[i-1];
          end else begin
            r_win[0] <= w_bucket;
          end
        end
      end
    end
  end

  assign qPush      = u_qif.push;
  assign qPop       = u_qif.pop;
  assign qInX       = input_x;
  assign qPushValid = u_qif.push_valid;
  assign qPopValid  = u_qif.pop;
  assign qOutX      = u_qif.head.x;
  assign qOutNewX   = u_qif.head.new_x;
  assign qWaitX     = r_eval.x;
  assign enA        = r_eval_valid & r_eval.new_x;
  assign enB        = r_eval_valid & r_eval.tick_b;
  assign stage      = {{(DATA_W-1){1'b0}}, r_eval_valid};
  assign timerB     = {{(DATA_W-TMR_W){1'b0}}, r_timer};
  assign winX_0     = r_win[0];
  assign winX_1     = r_win[1];
  assign outA       = r_out_a;
  assign aktvOutA   = r_aktv_a;
  assign outB       = r_out_b;
  assign aktvOutB   = r_aktv_b;

endmodule

// File: tb/tb_top_entity.sv
// Scoreboard bench for top_entity plus a direct fill/overflow test of event_queue.
module tb_top_entity;
  import top_entity_pkg::*;

  localparam int P = PERIOD_B;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               en = 1'b0;
  logic               new_input = 1'b0;
  logic signed [63:0] input_x = '0;

  logic               qPush, qPop, qPushValid, qPopValid, qOutNewX;
  logic               enA, enB, aktvOutA, aktvOutB;
  logic signed [63:0] qInX, qOutX, qWaitX, stage, timerB;
  logic signed [63:0] winX_0, winX_1, outA, outB;

  top_entity dut (
    .clk(clk), .rst(rst), .en(en), .input_x(input_x), .new_input(new_input),
    .qPush(qPush), .qPop(qPop), .qInX(qInX), .qPushValid(qPushValid),
    .qPopValid(qPopValid), .qOutX(qOutX), .qOutNewX(qOutNewX), .qWaitX(qWaitX),
    .enA(enA), .enB(enB), .stage(stage), .timerB(timerB),
    .winX_0(winX_0), .winX_1(winX_1), .outA(outA), .aktvOutA(aktvOutA),
    .outB(outB), .aktvOutB(aktvOutB)
  );

  top_entity_if u_qif ();
  event_queue u_q (.clk(clk), .rst(rst), .q(u_qif.slave));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  typedef struct {
    longint val;
    int     due;
  } exp_t;

  exp_t   qa[$];
  exp_t   qb[$];
  exp_t   ea, eb;
  int     en_cnt = 0;
  int     m_timer = 0;
  longint m_cur = 0, m_prev = 0, last_a = 0, last_b = 0;
  bit     mon_on = 1'b0;

  // One clock cycle of stimulus; expectations are derived from the A/B definitions.
  task automatic step(input bit e, input bit n, input longint x);
    bit tick;
    en = e; new_input = n; input_x = x;
    tick = (m_timer == P - 1);
    #1;
    check("qPush", qPush, e & (n | tick));
    check("qPushValid", qPushValid, e & (n | tick));
    check("qInX", qInX, x);
    @(posedge clk);
    if (e) begin
      en_cnt++;
      m_timer = tick ? 0 : m_timer + 1;
      if (n) begin
        m_cur += x;
        qa.push_back('{x, en_cnt + 2});
      end
      if (tick) begin
        qb.push_back('{m_cur + m_prev, en_cnt + 2});
        m_prev = m_cur;
        m_cur  = 0;
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 0);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b0; en = 1'b1; new_input = 1'b0; input_x = '0;
    @(posedge clk);
    m_timer = 0; m_cur = 0; m_prev = 0; last_a = 0; last_b = 0;
    qa.delete(); qb.delete();
    mon_on = 1'b1;
    repeat (cycles - 1) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic check_idle_state(input string tag);
    check({tag, "_outA"}, outA, 0);
    check({tag, "_outB"}, outB, 0);
    check({tag, "_aktvA"}, aktvOutA, 0);
    check({tag, "_aktvB"}, aktvOutB, 0);
    check({tag, "_timerB"}, timerB, 0);
    check({tag, "_winX_0"}, winX_0, 0);
    check({tag, "_winX_1"}, winX_1, 0);
    check({tag, "_stage"}, stage, 0);
    check({tag, "_enA_enB"}, {enA, enB}, 0);
    check({tag, "_qWaitX"}, qWaitX, 0);
    check({tag, "_qPop"}, qPop, 0);
    check({tag, "_qOutX"}, qOutX, 0);
  endtask

  // Output monitor: pops expected A/B results, checks value, latency and hold.
  always @(negedge clk) begin
    if (mon_on) begin
      if (aktvOutA) begin
        if (qa.size() == 0) check("aktvA_unexpected", aktvOutA, 0);
        else begin
          ea = qa.pop_front();
          check("outA", outA, ea.val);
          check("latency_A", en_cnt, ea.due);
          last_a = ea.val;
        end
      end else begin
        check("holdA", outA, last_a);
        if (qa.size() > 0 && en_cnt >= qa[0].due) begin
          check("missing_aktvA", aktvOutA, 1);
          void'(qa.pop_front());
        end
      end
      if (aktvOutB) begin
        if (qb.size() == 0) check("aktvB_unexpected", aktvOutB, 0);
        else begin
          eb = qb.pop_front();
          check("outB", outB, eb.val);
          check("latency_B", en_cnt, eb.due);
          last_b = eb.val;
        end
      end else begin
        check("holdB", outB, last_b);
        if (qb.size() > 0 && en_cnt >= qb[0].due) begin
          check("missing_aktvB", aktvOutB, 1);
          void'(qb.pop_front());
        end
      end
      check("timerB", timerB, m_timer);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  longint   sq[$];
  int       m_cnt;
  q_entry_t ent;

  initial begin
    u_qif.push = 1'b0; u_qif.pop = 1'b0; u_qif.push_data = '0;

    // Reset held for 5 cycles.
    do_reset(5);
    check_idle_state("reset");

    // Four consecutive events, then idle up to the tick cycle.
    step(1'b1, 1'b1, 1);
    step(1'b1, 1'b1, 2);
    step(1'b1, 1'b1, 3);
    step(1'b1, 1'b1, 4);
    idle(5);
    check("winX_0_after_1to4", winX_0, 10);
    check("winX_1_after_1to4", winX_1, 0);

    // Event on the tick cycle: B = 15, window slides.
    step(1'b1, 1'b1, 5);
    idle(2);
    check("winX_1_after_tick", winX_1, 15);
    check("winX_0_after_tick", winX_0, 0);

    // No inputs: B = 15 then 0 on the following ticks.
    idle(22);
    check("winX_1_drained", winX_1, 0);

    // Enable low for 3 cycles with an entry waiting in the queue.
    step(1'b1, 1'b1, 7);
    step(1'b0, 1'b1, 99);
    check("dis_stage", stage, 0);
    check("dis_qPop", qPop, 0);
    check("dis_qOutX", qOutX, 7);
    step(1'b0, 1'b1, 99);
    step(1'b0, 1'b1, 99);
    check("dis_timerB", timerB, 5);
    step(1'b1, 1'b1, 8);
    idle(3);
    check("winX_0_after_enable", winX_0, 15);

    // Modulo-2^64 wrap and negative values.
    step(1'b1, 1'b1, 64'sh7FFF_FFFF_FFFF_FFFF);
    step(1'b1, 1'b1, 1);
    step(1'b1, 1'b1, -5);
    idle(12);

    // Reset with an entry in flight: it must never be emitted.
    step(1'b1, 1'b1, 42);
    do_reset(3);
    check_idle_state("midreset");
    step(1'b1, 1'b1, -9);
    idle(3);
    check("winX_0_after_midreset", winX_0, -9);

    check("sb_drain_A", qa.size(), 0);
    check("sb_drain_B", qb.size(), 0);

    // Direct queue test: fill with pops stalled, overflow, push+pop at full, drain.
    en = 1'b0; new_input = 1'b0;
    m_cnt = 0;
    check("q_empty_init", u_qif.empty, 1);
    for (int i = 0; i < 5; i++) begin
      ent = '{x: 64'(11 + i), new_x: 1'b1, tick_b: 1'b0};
      u_qif.push = 1'b1; u_qif.pop = 1'b0; u_qif.push_data = ent;
      #1;
      check($sformatf("q_push_valid_%0d", i), u_qif.push_valid, (m_cnt < QUEUE_DEPTH) ? 1 : 0);
      @(posedge clk);
      if (m_cnt < QUEUE_DEPTH) begin
        sq.push_back(64'(11 + i));
        m_cnt++;
      end
      #1;
    end
    check("q_full", u_qif.full, 1);

    ent = '{x: 64'(16), new_x: 1'b1, tick_b: 1'b0};
    u_qif.push = 1'b1; u_qif.pop = 1'b1; u_qif.push_data = ent;
    #1;
    check("q_push_pop_at_full", u_qif.push_valid, 1);
    check("q_head_at_full", u_qif.head.x, sq[0]);
    @(posedge clk);
    void'(sq.pop_front());
    sq.push_back(16);
    #1;

    u_qif.push = 1'b0; u_qif.pop = 1'b1;
    for (int i = 0; i < 8 && sq.size() > 0; i++) begin
      #1;
      check($sformatf("q_order_%0d", i), u_qif.head.x, sq.pop_front());
      @(posedge clk);
      #1;
    end
    u_qif.pop = 1'b0;
    #1;
    check("q_empty_after_drain", u_qif.empty, 1);
    check("q_model_drained", sq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/top_entity.md
TOP_ENTITY -- requirements
Module: top_entity

Interface
REQ-001 The block SHALL have exactly one clock; reset is synchronous and active-low.
REQ-002 Parameter DATA_W, 64, signed width of stream data, window and debug words.
REQ-003 Parameter PERIOD_B, 10, clock cycles between evaluations of periodic output B.
REQ-004 Parameter WIN_BUCKETS, 2, number of per-period buckets in B's sliding window.
REQ-005 Parameter QUEUE_DEPTH, 4, number of event-queue entries.
REQ-006 Port list, in order:
- clk, in, 1, rising-edge clock.
- rst, in, 1, synchronous active-low reset.
- en, in, 1, global enable.
- input_x, in, 64 signed, sample of input stream x.
- new_input, in, 1, input_x carries a new value this cycle.
- qPush, out, 1, push requested.
- qPop, out, 1, pop requested.
- qInX, out, 64 signed, data being pushed.
- qPushValid, out, 1, push accepted.
- qPopValid, out, 1, pop performed.
- qOutX, out, 64 signed, queue head x.
- qOutNewX, out, 1, queue head newX flag.
- qWaitX, out, 64 signed, x held in the evaluation register.
- enA, out, 1, evaluation-register entry activates A.
- enB, out, 1, evaluation-register entry activates B.
- stage, out, 64 signed, 1 while an entry is evaluated, else 0.
- timerB, out, 64 signed, period counter.
- winX_0, out, 64 signed, current bucket sum.
- winX_1, out, 64 signed, previous bucket sum.
- outA, out, 64 signed, value of output A.
- aktvOutA, out, 1, outA updated this cycle.
- outB, out, 64 signed, value of output B.
- aktvOutB, out, 1, outB updated this cycle.

Function
REQ-007 Specification implemented: A := x (event-based, on every new x); B @ PERIOD_B cycles := sum of x over the last WIN_BUCKETS*PERIOD_B cycles.
REQ-008 While en=1, timerB SHALL count 0..PERIOD_B-1 and wrap to 0; a tick is asserted in the cycle timerB==PERIOD_B-1.
REQ-009 qPush = en & (new_input | tick); the pushed entry SHALL be {x=input_x, newX=new_input, tickB=tick}; qInX = input_x.
REQ-010 qPushValid = qPush & (not full | qPop); a push while full without a pop SHALL be dropped.
REQ-011 qPop = qPopValid = en & not empty; the head SHALL be popped each cycle; FIFO order; a simultaneous push and pop SHALL be legal at any fill level.
REQ-012 The popped entry SHALL be loaded into the evaluation register at the same edge; enA = newX, enB = tickB, and stage = 1 while the register is valid.
REQ-013 Evaluation, one edge later:
- If enA: outA <= x and aktvOutA <= 1.
- If newX: x is added into winX_0 first.
- If enB: outB <= winX_0(including x) + winX_1 and aktvOutB <= 1; then winX_1 <= that bucket and winX_0 <= 0.
REQ-014 Latency: an input sampled at edge k SHALL appear on outA/outB with aktv flags at edge k+2.
REQ-015 aktvOutA and aktvOutB SHALL be single-cycle pulses; outA and outB SHALL hold their values otherwise.
REQ-016 All arithmetic SHALL be two's-complement modulo 2^64, with no saturation.
REQ-017 With en=0: no push, no pop, and timerB, window and queue hold; aktv flags SHALL be 0.

Reset
REQ-018 With rst=0 at a rising edge, all of the following SHALL be cleared, taking priority over en:
- queue to empty;
- timerB, winX_0, winX_1, outA and outB to 0;
- all flags to 0;
- evaluation register to invalid.
REQ-019 Reset mid-operation SHALL discard queued and in-flight entries without emitting outputs.

Structure
REQ-020 A shared package SHALL hold DATA_W, PERIOD_B, WIN_BUCKETS, QUEUE_DEPTH and the queue-entry struct {x, newX, tickB}.
REQ-021 The FIFO SHALL be a sub-module named event_queue; timer, evaluation and window logic SHALL reside in top_entity.

Verification
REQ-022 Reset: hold rst=0 for 5 cycles -> all outputs 0 and queue empty.
REQ-023 Event-based output: push x=1,2,3,4 on 4 consecutive enabled cycles -> outA=1,2,3,4 on 4 consecutive cycles from edge k+2, each with aktvOutA=1; winX_0 reaches 10.
REQ-024 Event coinciding with a tick: after REQ-023, push x=5 on enabled cycle 9 (tick) -> outB=15 with aktvOutB=1, then winX_1=15 and winX_0=0.
REQ-025 Window slide: no further inputs -> outB=15 at the next tick and outB=0 at the one after.
REQ-026 Enable low: drop en for 3 cycles mid-stream -> timerB and window frozen, no aktv pulses, and count resumes on re-enable.
REQ-027 Queue full: force 5 pushes with pop stalled -> 5th qPushValid=0 and 4 entries are evaluated in order.
